hex_display_arbiter: RTL and testbench
======================================

Name: hex_display_arbiter

Overview:
- Time-shares the 4-digit seven-segment display between NUM_REQ requesters, e.g. debug counters, FSM state and address probes.
- Sits directly upstream of the hex display driver. Its digits output drives the driver's 4 x 4-bit nibble input.
- Round-robin arbitration with a minimum dwell time per owner, so each value stays readable on the board.

Parameters:
- NUM_REQ, 4: number of requesters. Legal range 2..8.
- DWELL_CYCLES, 50000000: minimum clk cycles an owner holds the display once others are waiting. Must be >= 2.
- IDX_W, $clog2(NUM_REQ): width of owner index. Derived; do not override.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low. 0 = reset asserted.
- req  input  NUM_REQ  per-requester display request, level-sensitive.
- value  input  NUM_REQ x 16  per-requester value; nibble k = value[i][4k+3:4k].
- lock  input  NUM_REQ  per-requester dwell-extend. Present only under HEX_ARB_LOCK_EN.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- owner  output  IDX_W  index of current owner; 0 when idle.
- digits  output  4 x 4  nibbles to the display driver; digits[k] = nibble k of owner's value.
- active  output  1  high while a requester owns the display.

Behaviour:
- Async reset (reset=0):
  - FSM to IDLE.
  - grant=0, owner=0, digits all 4'h0, active=0.
  - Dwell counter=0; round-robin pointer rr=0.
  - Takes effect immediately, including mid-dwell.
- State IDLE:
  - active=0, outputs held at reset values.
  - If any req bit is set, pick the first set bit scanning rr, rr+1, ... modulo NUM_REQ.
  - Next cycle: enter SHOW, grant/owner set to that requester, counter=0, rr=owner+1 mod NUM_REQ.
- State SHOW:
  - digits registered from value[owner] every cycle: 1-cycle latency, live update.
  - Counter increments each cycle, saturating at DWELL_CYCLES-1.
- SHOW transitions, priority order:
  1. req[owner]=0: release next cycle. Re-arbitrate from rr among remaining requests. If none, go to IDLE and clear digits to 0. Dwell is not required.
  2. Counter at DWELL_CYCLES-1 and another req bit set: switch to the next requester scanning from rr, counter=0, rr updated.
  3. Counter at DWELL_CYCLES-1 and only the owner requests: stay; counter holds saturated; switch happens the first cycle another request appears.
- Switch timing:
  - grant, owner and digits change together on the same clk edge.
  - Never more than one grant bit set.
  - grant is never 0 while active=1.
- Simultaneous events:
  - Owner dropping req in the same cycle as dwell expiry resolves as rule 1.
  - New requests arriving the same cycle as a switch are seen by that cycle's scan.
- rr wraps NUM_REQ-1 -> 0.

Optional Feature:
- Macro: HEX_ARB_LOCK_EN.
- Defined: lock port exists. While lock[owner]=1, rule 2 is suppressed and the counter holds saturated. Rule 1 still applies. Deasserting lock re-enables rule 2 on the next cycle.
- Undefined: lock port absent; behaviour exactly as above.

Test Plan (DWELL_CYCLES=8, NUM_REQ=4):
- Reset then req=4'b0100, value[2]=16'hBEEF -> 1 cycle later grant=4'b0100, owner=2, active=1; next cycle digits={F,E,E,B} (k=0..3). Drop req -> IDLE, digits=0, active=0.
- req=4'b1111 held -> owners 0,1,2,3,0 in order, each grant exactly 8 cycles, one-hot throughout.
- Owner 0 alone for 20 cycles, then req[3] rises -> grant moves to 3 one cycle after req[3] is sampled.
- Owner 1 drops req at counter=3 with req[2] set -> grant=4'b0100 next cycle, counter=0.
- Assert reset mid-dwell with owner 2 -> grant, owner, digits and active clear without waiting for a clk edge. After release with req=4'b0110, first grant goes to 1 (rr=0).
- HEX_ARB_LOCK_EN defined: owner 0 holds lock=1 with req=4'b0011 for 30 cycles -> grant stays 4'b0001. Lock drops -> grant=4'b0010 within 2 cycles.

Source files
------------

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the 4-digit hex display with a minimum dwell per owner.
// Optional HEX_ARB_LOCK_EN adds a per-requester lock input that extends the dwell.
module hex_display_arbiter #(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned DWELL_CYCLES = 50000000,
  localparam int unsigned IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0][15:0] value,
`ifdef HEX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       lock,
`endif
  output logic [NUM_REQ-1:0]       grant,
  output logic [IDX_W-1:0]         owner,
  output logic [3:0][3:0]          digits,
  output logic                     active
);

  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [IDX_W-1:0]     owner_d;
  logic [3:0][3:0]      digits_d;
  logic                 active_d;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [SUM_W-1:0]     scan_sum;
  logic [IDX_W-1:0]     scan_idx;
  logic                 others;
  logic                 hold;
  logic                 take;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // First requesting index found scanning upward from the round-robin pointer
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_q} + SUM_W'(i);
      if (scan_sum >= SUM_W'(NUM_REQ)) begin
        scan_sum = scan_sum - SUM_W'(NUM_REQ);
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign others = |(req & ~grant);

`ifdef HEX_ARB_LOCK_EN
  assign hold = lock[owner];
`else
  assign hold = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    grant_d  = grant;
    owner_d  = owner;
    digits_d = digits;
    active_d = active;
    take     = 1'b0;

    case (state_q)
      IDLE: begin
        take = pick_found;
      end
      SHOW: begin
        digits_d = value[owner];
        if (!req[owner]) begin
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_d  = IDLE;
            cnt_d    = '0;
            grant_d  = '0;
            owner_d  = '0;
            digits_d = '0;
            active_d = 1'b0;
          end
        end else if ((cnt_q == CNT_MAX) && others && !hold) begin
          take = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // New owner: grant, owner and digits all update on the same edge
    if (take) begin
      state_d           = SHOW;
      cnt_d             = '0;
      rr_d              = next_idx(pick_idx);
      grant_d           = '0;
      grant_d[pick_idx] = 1'b1;
      owner_d           = pick_idx;
      digits_d          = value[pick_idx];
      active_d          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      grant   <= '0;
      owner   <= '0;
      digits  <= '0;
      active  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      grant   <= grant_d;
      owner   <= owner_d;
      digits  <= digits_d;
      active  <= active_d;
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Randomized and directed bench for hex_display_arbiter against a cycle-level reference model.
module tb_hex_display_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DWELL   = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0][15:0] value;
`ifdef HEX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       lock;
`endif
  logic [NUM_REQ-1:0]       grant;
  logic [1:0]               owner;
  logic [3:0][3:0]          digits;
  logic                     active;

  hex_display_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .value  (value),
`ifdef HEX_ARB_LOCK_EN
    .lock   (lock),
`endif
    .grant  (grant),
    .owner  (owner),
    .digits (digits),
    .active (active)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the display, for how many cycles, and the rr pointer
  bit          m_active;
  int          m_owner;
  int          m_held;
  int          m_rr;
  logic [15:0] m_dig;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_held   = 0;
    m_rr     = 0;
    m_dig    = 16'h0;
  endfunction

  function automatic int model_scan();
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      int c = (m_rr + i) % int'(NUM_REQ);
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_take(input int p);
    m_active = 1'b1;
    m_owner  = p;
    m_held   = 0;
    m_rr     = (p + 1) % int'(NUM_REQ);
    m_dig    = value[p];
  endfunction

  function automatic void model_step();
    int p = model_scan();
    bit lk = 1'b0;
    bit others;
`ifdef HEX_ARB_LOCK_EN
    lk = lock[m_owner];
`endif
    others = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (i != m_owner && req[i]) others = 1'b1;
    end
    if (!m_active) begin
      if (p >= 0) model_take(p);
    end else if (!req[m_owner]) begin
      if (p >= 0) model_take(p);
      else model_reset_outputs();
    end else if (m_held >= int'(DWELL) - 1 && others && !lk) begin
      model_take(p);
    end else begin
      m_held++;
      m_dig = value[m_owner];
    end
  endfunction

  function automatic void model_reset_outputs();
    m_active = 1'b0;
    m_owner  = 0;
    m_held   = 0;
    m_dig    = 16'h0;
  endfunction

  task automatic compare_all();
    logic [NUM_REQ-1:0] exp_grant;
    exp_grant = '0;
    if (m_active) exp_grant[m_owner] = 1'b1;
    check("active", 32'(active), 32'(m_active));
    check("grant", 32'(grant), 32'(exp_grant));
    check("owner", 32'(owner), 32'(m_owner));
    check("digits", 32'(digits), 32'(m_dig));
    check("onehot", 32'($countones(grant) <= 1), 32'd1);
  endtask

  // One clock: model sees the same pre-edge inputs as the DUT, outputs sampled 1ns later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic sync_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    value = '0;
`ifdef HEX_ARB_LOCK_EN
    lock  = '0;
`endif
    model_reset();
    #3;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_digits", 32'(digits), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single requester: grant next edge, digits follow owner's value, release clears
    for (int i = 0; i < int'(NUM_REQ); i++) value[i] = 16'($urandom);
    value[2] = 16'hBEEF;
    req = 4'b0100;
    tick();
    check("t1_grant", 32'(grant), 32'h4);
    check("t1_owner", 32'(owner), 32'd2);
    check("t1_active", 32'(active), 32'd1);
    tick();
    check("t1_digits", 32'(digits), 32'hBEEF);
    req = 4'b0000;
    tick();
    check("t1_idle_active", 32'(active), 32'd0);
    check("t1_idle_digits", 32'(digits), 32'd0);

    // All requesting: strict rotation 0,1,2,3,0 with DWELL cycles each
    sync_reset();
    req = 4'b1111;
    for (int t = 0; t < 40; t++) begin
      tick();
      check("rot_owner", 32'(owner), 32'((t / int'(DWELL)) % 4));
    end

    // Sole owner long past dwell: switch on the first edge that sees another request
    sync_reset();
    req = 4'b0001;
    repeat (20) tick();
    req = 4'b1001;
    tick();
    check("late_switch", 32'(grant), 32'h8);

    // Owner drops mid-dwell: immediate handoff, fresh dwell for the new owner
    sync_reset();
    req = 4'b0010;
    repeat (4) tick();
    req = 4'b0100;
    tick();
    check("drop_grant", 32'(grant), 32'h4);
    req = 4'b0110;
    repeat (int'(DWELL) - 1) tick();
    check("drop_dwell_hold", 32'(grant), 32'h4);
    tick();
    check("drop_dwell_switch", 32'(grant), 32'h2);

    // Asynchronous reset mid-dwell, then rr restarts at 0
    sync_reset();
    req = 4'b0100;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_owner", 32'(owner), 32'd0);
    check("async_digits", 32'(digits), 32'd0);
    check("async_active", 32'(active), 32'd0);
    model_reset();
    req = 4'b0110;
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_rst_owner", 32'(owner), 32'd1);

`ifdef HEX_ARB_LOCK_EN
    // Lock holds ownership past dwell; releasing it hands off promptly
    sync_reset();
    req  = 4'b0011;
    lock = 4'b0001;
    for (int t = 0; t < 30; t++) begin
      tick();
      check("lock_hold", 32'(grant), 32'h1);
    end
    lock = 4'b0000;
    tick();
    tick();
    check("lock_release", 32'(grant), 32'h2);
`endif

    // Randomized traffic with occasional asynchronous resets
    sync_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) value[$urandom_range(0, 3)] = 16'($urandom);
`ifdef HEX_ARB_LOCK_EN
      if ($urandom_range(0, 15) == 0) lock = 4'($urandom) & 4'($urandom);
`endif
      if ($urandom_range(0, 399) == 0) sync_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
